// File: rtl/bcd_freq_gen_if.sv
// Request/status bundle of the BCD-programmed square-wave generator.
// The master drives the digits and load; the slave reports status and the wave.
interface bcd_freq_gen_if;
    logic        load;
    logic [3:0]  seg0;
    logic [3:0]  seg1;
    logic [3:0]  seg2;
    logic [3:0]  seg3;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] freq_bin;
    logic        freq_out;

    modport master (
        output load, seg0, seg1, seg2, seg3,
        input  busy, done, err, freq_bin, freq_out
    );

    modport slave (
        input  load, seg0, seg1, seg2, seg3,
        output busy, done, err, freq_bin, freq_out
    );
endinterface

// File: rtl/bcd_freq_gen.sv
// Four-digit BCD frequency in, 50 % square wave out: serial BCD-to-binary
// conversion followed by a phase-accumulator divider stepping by 2*f per clock.
module bcd_freq_gen #(
    parameter int CLK_FRE = 12_000_000,
    parameter int ACC_W   = 25
) (
    input  logic           clk,
    input  logic           rst,
    bcd_freq_gen_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CONV, RUN} state_t;

    localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_FRE);

    state_t             state_q, state_d;
    logic               prev_run_q, prev_run_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        digits_q, digits_d;
    logic [13:0]        bin_q, bin_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [13:0]        freq_bin_q, freq_bin_d;
    logic               freq_out_q, freq_out_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   inc_q, inc_d;

    logic [3:0]         cur_digit;
    logic [13:0]        bin_next;
    logic [ACC_W-1:0]   bin_x2;
    logic [ACC_W-1:0]   acc_sum;
    logic               bad_digit;

    always_comb begin
        state_d    = state_q;
        prev_run_d = prev_run_q;
        idx_d      = idx_q;
        digits_d   = digits_q;
        bin_d      = bin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        freq_bin_d = freq_bin_q;
        freq_out_d = freq_out_q;
        acc_d      = acc_q;
        inc_d      = inc_q;

        // Thousands digit first, so the latched word is consumed from the top nibble down.
        case (idx_q)
            2'd0:    cur_digit = digits_q[15:12];
            2'd1:    cur_digit = digits_q[11:8];
            2'd2:    cur_digit = digits_q[7:4];
            default: cur_digit = digits_q[3:0];
        endcase
        bin_next  = bin_q * 14'd10 + {10'd0, cur_digit};
        bin_x2    = ACC_W'({bin_next, 1'b0});
        acc_sum   = acc_q + inc_q;
        bad_digit = (bus.seg0 > 4'd9) || (bus.seg1 > 4'd9) ||
                    (bus.seg2 > 4'd9) || (bus.seg3 > 4'd9);

        // The divider free-runs in every state; with a zero increment it never toggles.
        if (acc_sum >= CLK_LIM) begin
            acc_d      = acc_sum - CLK_LIM;
            freq_out_d = ~freq_out_q;
        end else begin
            acc_d      = acc_sum;
        end

        case (state_q)
            IDLE, RUN: begin
                if (bus.load) begin
                    if (bad_digit) begin
                        err_d = 1'b1;
                    end else begin
                        digits_d   = {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
                        bin_d      = 14'd0;
                        idx_d      = 2'd0;
                        prev_run_d = (state_q == RUN);
                        state_d    = CONV;
                        busy_d     = 1'b1;
                        err_d      = 1'b0;
                    end
                end
            end
            CONV: begin
                bin_d = bin_next;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    busy_d = 1'b0;
                    if (bin_x2 >= CLK_LIM) begin
                        err_d   = 1'b1;
                        state_d = prev_run_q ? RUN : IDLE;
                    end else if (bin_next == 14'd0) begin
                        freq_bin_d = 14'd0;
                        inc_d      = '0;
                        acc_d      = '0;
                        freq_out_d = 1'b0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                    end else begin
                        // Phase restarts but the level is held, avoiding a runt pulse.
                        freq_bin_d = bin_next;
                        inc_d      = bin_x2;
                        acc_d      = '0;
                        freq_out_d = freq_out_q;
                        state_d    = RUN;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_run_q <= 1'b0;
            idx_q      <= 2'd0;
            digits_q   <= 16'd0;
            bin_q      <= 14'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            freq_bin_q <= 14'd0;
            freq_out_q <= 1'b0;
            acc_q      <= '0;
            inc_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_run_q <= prev_run_d;
            idx_q      <= idx_d;
            digits_q   <= digits_d;
            bin_q      <= bin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            freq_bin_q <= freq_bin_d;
            freq_out_q <= freq_out_d;
            acc_q      <= acc_d;
            inc_q      <= inc_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.freq_bin = freq_bin_q;
    assign bus.freq_out = freq_out_q;

endmodule
